// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a load/ready handshake.
// A word loaded on the last-bit cycle follows the current word with no idle gap.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | no word in flight, dout at IDLE_LEVEL, accepting
    // SHIFT | word in flight, bit at cnt on dout
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign accept   = load && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                ready = (cnt == LAST);
                busy  = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    // The first bit goes straight to dout on acceptance; sreg keeps the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            cnt        <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else if (accept) begin
            sreg       <= (MSB_FIRST != 0) ? (data_in << 1) : (data_in >> 1);
            dout       <= (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
            cnt        <= '0;
            dout_valid <= 1'b1;
            done       <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                dout       <= IDLE_LEVEL;
                dout_valid <= 1'b0;
                done       <= 1'b0;
            end else begin
                sreg       <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
                dout       <= (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
                cnt        <= cnt + CW'(1);
                dout_valid <= 1'b1;
                done       <= (cnt == PENULT);
            end
        end
    end

endmodule
